// File: rtl/decod_letras_if.sv
// Output stream of decoded letters: FIFO head with valid/ready handshake.
// master = producer (decod_letras), slave = consumer (game logic).
interface decod_letras_if;
    logic [4:0] letra;
    logic       letra_valid;
    logic       letra_ready;
    logic       desconocido;

    modport master (output letra, output letra_valid, output desconocido, input letra_ready);
    modport slave  (input letra, input letra_valid, input desconocido, output letra_ready);
endinterface

// File: rtl/decod_letras.sv
// Decodes debounced 7-segment patterns back to letter indices 0-25 into a small FIFO.
// Optional macro DECOD_DESCONOCIDO_EN: also push unknown stable patterns as index 31.
module decod_letras #(
    parameter int ESTABLE = 4,
    parameter int PROF    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [6:0]             seg_in,
    decod_letras_if.master         sal,
    output logic                   desborde,
    output logic [$clog2(PROF):0]  ocupacion
);
    localparam int CW = $clog2(ESTABLE + 1);
    localparam int PW = $clog2(PROF);
    localparam int OW = PW + 1;

    // Letter patterns, A in the least significant slot through Z in the most significant.
    localparam logic [26*7-1:0] PATRONES = {
        7'd73,  7'd110, 7'd112, 7'd29,  7'd62,  7'd28,  7'd120, 7'd109, 7'd80,
        7'd103, 7'd115, 7'd63,  7'd84,  7'd55,  7'd56,  7'd122, 7'd30,  7'd25,
        7'd118, 7'd111, 7'd113, 7'd121, 7'd94,  7'd57,  7'd124, 7'd119
    };

    typedef enum logic [1:0] {VACIO, CONTANDO, RETENIDO} estado_t;

    estado_t         estado_reg;
    logic [6:0]      seg_q;
    logic [6:0]      cand_reg;
    logic [CW-1:0]   cnt_reg;

    logic [25:0]     coincide;
    logic [4:0]      indice;
    logic            estable_hit;
    logic            push;

    genvar gi;
    generate
        for (gi = 0; gi < 26; gi++) begin : g_rom
            assign coincide[gi] = (cand_reg == PATRONES[gi*7 +: 7]);
        end
    endgenerate

    always_comb begin
        indice = 5'd31;
        for (int i = 0; i < 26; i++) begin
            if (coincide[i]) indice = 5'(i);
        end
    end

    assign estable_hit = (estado_reg == CONTANDO) && (cnt_reg == CW'(ESTABLE));

`ifdef DECOD_DESCONOCIDO_EN
    assign push = estable_hit;
`else
    assign push = estable_hit && (indice != 5'd31);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q      <= '0;
            cand_reg   <= '0;
            cnt_reg    <= '0;
            estado_reg <= VACIO;
        end else begin
            seg_q <= seg_in;
            case (estado_reg)
                VACIO: begin
                    if (seg_q != 7'd0) begin
                        cand_reg   <= seg_q;
                        cnt_reg    <= CW'(1);
                        estado_reg <= CONTANDO;
                    end
                end
                CONTANDO: begin
                    // The window is complete: the push fires this cycle, whatever seg_q shows now.
                    if (cnt_reg == CW'(ESTABLE)) begin
                        estado_reg <= RETENIDO;
                    end else if (seg_q == 7'd0) begin
                        estado_reg <= VACIO;
                    end else if (seg_q == cand_reg) begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end else begin
                        cand_reg <= seg_q;
                        cnt_reg  <= CW'(1);
                    end
                end
                RETENIDO: begin
                    if (seg_q == 7'd0) begin
                        estado_reg <= VACIO;
                    end else if (seg_q != cand_reg) begin
                        cand_reg   <= seg_q;
                        cnt_reg    <= CW'(1);
                        estado_reg <= CONTANDO;
                    end
                end
                default: estado_reg <= VACIO;
            endcase
        end
    end

    logic [4:0]    mem [PROF];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [OW-1:0] ocup_reg;
    logic [4:0]    letra_reg;
    logic          desborde_reg;
    logic          pop;
    logic          lleno;
    logic          escribe;

    assign pop     = (ocup_reg != '0) && sal.letra_ready;
    assign lleno   = (ocup_reg == OW'(PROF));
    assign escribe = push && (!lleno || pop);

    always_ff @(posedge clk) begin
        if (escribe) mem[wr_ptr_reg] <= indice;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            ocup_reg     <= '0;
            letra_reg    <= '0;
            desborde_reg <= 1'b0;
        end else begin
            if (escribe) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)     rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({escribe, pop})
                2'b10:   ocup_reg <= ocup_reg + OW'(1);
                2'b01:   ocup_reg <= ocup_reg - OW'(1);
                default: ocup_reg <= ocup_reg;
            endcase
            if (push && lleno && !pop) desborde_reg <= 1'b1;
            // Head register: bypass the new entry when it becomes the head, else prefetch the next slot.
            if (escribe && ((ocup_reg == '0) || (pop && ocup_reg == OW'(1)))) begin
                letra_reg <= indice;
            end else if (pop && ocup_reg > OW'(1)) begin
                letra_reg <= mem[rd_ptr_reg + PW'(1)];
            end
        end
    end

    assign sal.letra       = letra_reg;
    assign sal.letra_valid = (ocup_reg != '0);
`ifdef DECOD_DESCONOCIDO_EN
    assign sal.desconocido = (letra_reg == 5'd31);
`else
    assign sal.desconocido = 1'b0;
`endif
    assign desborde  = desborde_reg;
    assign ocupacion = ocup_reg;
endmodule
